// File: rtl/vga_console_ctrl_if.sv
// Bus bundle for vga_console_ctrl: CPU cell-write port, keyboard stream,
// text-RAM write port and cursor/status outputs.
interface vga_console_ctrl_if;
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;
   localparam int unsigned XW = 7;
   localparam int unsigned YW = 5;

   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_data;
   logic          cpu_ack;
   logic          kbd_valid;
   logic [DW-1:0] kbd_char;
   logic          kbd_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [XW-1:0] cursor_x;
   logic [YW-1:0] cursor_y;
   logic          busy;

   // Controller side
   modport slave (
      input  cpu_req, cpu_addr, cpu_data, kbd_valid, kbd_char,
      output cpu_ack, kbd_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, busy
   );

   // Environment side (CPU, keyboard, text RAM)
   modport master (
      output cpu_req, cpu_addr, cpu_data, kbd_valid, kbd_char,
      input  cpu_ack, kbd_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, busy
   );
endinterface

// File: rtl/vga_console_ctrl.sv
// Text console controller: arbitrates CPU cell writes and keyboard input onto a
// text-RAM write port. Define VGA_CON_CLEAR_EN for the clear-screen (0x0C) feature.
module vga_console_ctrl #(
   parameter int unsigned COLS  = 70,
   parameter int unsigned ROWS  = 30,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input logic               sys_clk,
   input logic               rst,
   vga_console_ctrl_if.slave bus
);

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;
   localparam int unsigned XW = 7;
   localparam int unsigned YW = 5;

   localparam logic [AW-1:0] CELLS    = AW'(COLS * ROWS);
   localparam logic [AW-1:0] COLS_A   = AW'(COLS);
   localparam logic [XW-1:0] LAST_COL = XW'(COLS - 1);
   localparam logic [YW-1:0] LAST_ROW = YW'(ROWS - 1);

   localparam logic [DW-1:0] CH_BS = 8'h08;
   localparam logic [DW-1:0] CH_LF = 8'h0A;
`ifdef VGA_CON_CLEAR_EN
   localparam logic [DW-1:0] CH_FF = 8'h0C;
`endif

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LINECLR = 2'd1
`ifdef VGA_CON_CLEAR_EN
      , S_CLEAR = 2'd2
`endif
   } state_e;

`ifdef VGA_CON_CLEAR_EN
   localparam state_e RST_STATE = S_CLEAR;
   localparam logic   RST_BUSY  = 1'b1;
`else
   localparam state_e RST_STATE = S_IDLE;
   localparam logic   RST_BUSY  = 1'b0;
`endif

   // row*COLS as a sum of shifted copies of row, one per set bit of COLS
   function automatic logic [AW-1:0] row_base(input logic [YW-1:0] row);
      logic [AW-1:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < AW; i++) begin
         if (COLS_A[i]) acc = acc + (AW'(row) << i);
      end
      return acc;
   endfunction

   state_e        state_q;
   logic          last_kbd_q;
   logic          cpu_ack_q;
   logic          wr_en_q;
   logic [AW-1:0] wr_addr_q;
   logic [DW-1:0] wr_data_q;
   logic [XW-1:0] cx_q;
   logic [YW-1:0] cy_q;
   logic          busy_q;
   logic [XW-1:0] clr_col_q;
`ifdef VGA_CON_CLEAR_EN
   logic [AW-1:0] clr_addr_q;
`endif

   logic          idle_c;
   logic          cpu_pend_c;
   logic          grant_cpu_c;
   logic          grant_kbd_c;
   logic          kbd_ready_c;
   logic          printable_c;
   logic          row_adv_c;
   logic          row_wrap_c;
   logic [YW-1:0] next_row_c;
   logic [AW-1:0] row_base_c;
   logic [AW-1:0] cell_c;

   // Arbitration and keyboard decode; a just-acked request is not pending again
   always_comb begin
      idle_c      = 1'b0;
      cpu_pend_c  = 1'b0;
      grant_cpu_c = 1'b0;
      grant_kbd_c = 1'b0;
      kbd_ready_c = 1'b0;
      printable_c = 1'b0;
      row_adv_c   = 1'b0;
      row_wrap_c  = 1'b0;
      next_row_c  = '0;
      row_base_c  = '0;
      cell_c      = '0;

      idle_c      = (state_q == S_IDLE);
      cpu_pend_c  = bus.cpu_req && !cpu_ack_q;
      grant_cpu_c = idle_c && cpu_pend_c && (!bus.kbd_valid || last_kbd_q);
      grant_kbd_c = idle_c && bus.kbd_valid && (!cpu_pend_c || !last_kbd_q);
      kbd_ready_c = idle_c && (grant_kbd_c || !bus.cpu_req);

      printable_c = (bus.kbd_char >= 8'h20) && (bus.kbd_char <= 8'h7E);
      row_adv_c   = grant_kbd_c &&
                    ((printable_c && (cx_q == LAST_COL)) || (bus.kbd_char == CH_LF));
      row_wrap_c  = (cy_q == LAST_ROW);
      next_row_c  = row_wrap_c ? '0 : cy_q + YW'(1);
      row_base_c  = row_base(cy_q);
      cell_c      = row_base_c + AW'(cx_q);
   end

   // State machine with registered write port, ack, cursor and busy
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= RST_STATE;
         last_kbd_q <= 1'b1;
         cpu_ack_q  <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         busy_q     <= RST_BUSY;
         clr_col_q  <= '0;
`ifdef VGA_CON_CLEAR_EN
         clr_addr_q <= '0;
`endif
      end else begin
         cpu_ack_q <= 1'b0;
         wr_en_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_cpu_c) begin
                  last_kbd_q <= 1'b0;
                  cpu_ack_q  <= 1'b1;
                  if (bus.cpu_addr < CELLS) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= bus.cpu_addr;
                     wr_data_q <= bus.cpu_data;
                  end
               end else if (grant_kbd_c) begin
                  last_kbd_q <= 1'b1;
                  if (printable_c) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= cell_c;
                     wr_data_q <= bus.kbd_char;
                     cx_q      <= (cx_q == LAST_COL) ? '0 : cx_q + XW'(1);
                  end else if (bus.kbd_char == CH_LF) begin
                     cx_q <= '0;
                  end else if (bus.kbd_char == CH_BS) begin
                     if (cx_q != '0) begin
                        cx_q      <= cx_q - XW'(1);
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cell_c - AW'(1);
                        wr_data_q <= BLANK;
                     end
`ifdef VGA_CON_CLEAR_EN
                  end else if (bus.kbd_char == CH_FF) begin
                     state_q    <= S_CLEAR;
                     busy_q     <= 1'b1;
                     clr_addr_q <= '0;
`endif
                  end
                  if (row_adv_c) begin
                     cy_q <= next_row_c;
                     if (row_wrap_c) begin
                        state_q   <= S_LINECLR;
                        busy_q    <= 1'b1;
                        clr_col_q <= '0;
                     end
                  end
               end
            end

            S_LINECLR: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= row_base_c + AW'(clr_col_q);
               wr_data_q <= BLANK;
               clr_col_q <= clr_col_q + XW'(1);
               if (clr_col_q == LAST_COL) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end

`ifdef VGA_CON_CLEAR_EN
            S_CLEAR: begin
               wr_en_q    <= 1'b1;
               wr_addr_q  <= clr_addr_q;
               wr_data_q  <= BLANK;
               clr_addr_q <= clr_addr_q + AW'(1);
               if (clr_addr_q == CELLS - AW'(1)) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  cx_q    <= '0;
                  cy_q    <= '0;
               end
            end
`endif

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.kbd_ready = kbd_ready_c;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.cursor_x  = cx_q;
   assign bus.cursor_y  = cy_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Self-checking bench for vga_console_ctrl: directed vector table plus
// hand-written sequences for arbitration, last-row wrap and reset abort.
module tb_vga_console_ctrl;

   localparam int unsigned CELLS = 2100;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   vga_console_ctrl_if bus ();

   vga_console_ctrl dut (
      .sys_clk (clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        cpu;
      logic [11:0] addr;
      logic [7:0]  ch;
      logic        wen;
      logic [11:0] waddr;
      logic [7:0]  wdata;
      logic [6:0]  cx;
      logic [4:0]  cy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic cpu, input logic [11:0] addr, input logic [7:0] ch,
                               input logic wen, input logic [11:0] waddr, input logic [7:0] wdata,
                               input logic [6:0] cx, input logic [4:0] cy);
      vec_t v;
      v.cpu = cpu; v.addr = addr; v.ch = ch; v.wen = wen;
      v.waddr = waddr; v.wdata = wdata; v.cx = cx; v.cy = cy;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic chk_cur(input string name, input int x, input int y);
      chk({name, "_cx"}, 32'(bus.cursor_x), 32'(x));
      chk({name, "_cy"}, 32'(bus.cursor_y), 32'(y));
   endtask

   task automatic send_kbd(input logic [7:0] c);
      bus.kbd_valid = 1'b1;
      bus.kbd_char  = c;
      #1;
      chk("kbd_ready_before_send", 32'(bus.kbd_ready), 1);
      tick();
      bus.kbd_valid = 1'b0;
   endtask

   task automatic send_n(input logic [7:0] c, input int n);
      for (int i = 0; i < n; i++) send_kbd(c);
   endtask

   // Expects CELLS ascending BLANK writes, then idle with cursor homed
   task automatic chk_clear();
      int bad;
      bad = 0;
      for (int n = 0; n < CELLS; n++) begin
         tick();
         if (!(bus.wr_en === 1'b1 && bus.wr_addr === 12'(n) && bus.wr_data === 8'h20)) bad++;
      end
      chk("clear_bad_writes", 32'(bad), 0);
      chk("clear_busy_end", 32'(bus.busy), 0);
      chk_cur("clear_end", 0, 0);
      tick();
      chk("clear_wr_en_after", 32'(bus.wr_en), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      chk("rst_wr_en", 32'(bus.wr_en), 0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 0);
      chk("rst_wr_data", 32'(bus.wr_data), 0);
      chk("rst_cpu_ack", 32'(bus.cpu_ack), 0);
      chk_cur("rst", 0, 0);
`ifdef VGA_CON_CLEAR_EN
      chk("rst_busy", 32'(bus.busy), 1);
      rst = 1'b0;
      chk_clear();
`else
      chk("rst_busy", 32'(bus.busy), 0);
      rst = 1'b0;
`endif
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      n_pass = 0;
      n_total = 0;
      bus.cpu_req = 1'b0;
      bus.cpu_addr = '0;
      bus.cpu_data = '0;
      bus.kbd_valid = 1'b0;
      bus.kbd_char = '0;

      //           cpu  addr   ch     wen waddr  wdata  cx  cy
      tbl.push_back(mk(0, 12'd0, 8'h41, 1, 12'd0,   8'h41, 1, 0));
      tbl.push_back(mk(0, 12'd0, 8'h42, 1, 12'd1,   8'h42, 2, 0));
      tbl.push_back(mk(0, 12'd0, 8'h08, 1, 12'd1,   8'h20, 1, 0));
      tbl.push_back(mk(0, 12'd0, 8'h07, 0, 12'd0,   8'h00, 1, 0));
      tbl.push_back(mk(0, 12'd0, 8'h7F, 0, 12'd0,   8'h00, 1, 0));
`ifndef VGA_CON_CLEAR_EN
      tbl.push_back(mk(0, 12'd0, 8'h0C, 0, 12'd0,   8'h00, 1, 0));
`endif
      tbl.push_back(mk(0, 12'd0, 8'h0A, 0, 12'd0,   8'h00, 0, 1));
      tbl.push_back(mk(0, 12'd0, 8'h0A, 0, 12'd0,   8'h00, 0, 2));
      tbl.push_back(mk(0, 12'd0, 8'h0A, 0, 12'd0,   8'h00, 0, 3));
      tbl.push_back(mk(0, 12'd0, 8'h08, 0, 12'd0,   8'h00, 0, 3));
      tbl.push_back(mk(0, 12'd0, 8'h68, 1, 12'd210, 8'h68, 1, 3));
      tbl.push_back(mk(0, 12'd0, 8'h69, 1, 12'd211, 8'h69, 2, 3));
      tbl.push_back(mk(0, 12'd0, 8'h7E, 1, 12'd212, 8'h7E, 3, 3));
      tbl.push_back(mk(0, 12'd0, 8'h20, 1, 12'd213, 8'h20, 4, 3));
      tbl.push_back(mk(0, 12'd0, 8'h21, 1, 12'd214, 8'h21, 5, 3));
      tbl.push_back(mk(0, 12'd0, 8'h08, 1, 12'd214, 8'h20, 4, 3));
      tbl.push_back(mk(0, 12'd0, 8'h1F, 0, 12'd0,   8'h00, 4, 3));
      tbl.push_back(mk(1, 12'd75,   8'h5A, 1, 12'd75,   8'h5A, 4, 3));
      tbl.push_back(mk(1, 12'd2100, 8'h11, 0, 12'd0,    8'h00, 4, 3));
      tbl.push_back(mk(1, 12'd2099, 8'h33, 1, 12'd2099, 8'h33, 4, 3));
      tbl.push_back(mk(1, 12'd4095, 8'hFF, 0, 12'd0,    8'h00, 4, 3));

      do_reset();

      foreach (tbl[i]) begin
         if (tbl[i].cpu) begin
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = tbl[i].addr;
            bus.cpu_data = tbl[i].ch;
            tick();
            bus.cpu_req  = 1'b0;
         end else begin
            send_kbd(tbl[i].ch);
         end
         chk($sformatf("vec%0d_wr_en", i), 32'(bus.wr_en), 32'(tbl[i].wen));
         if (tbl[i].wen) begin
            chk($sformatf("vec%0d_wr_addr", i), 32'(bus.wr_addr), 32'(tbl[i].waddr));
            chk($sformatf("vec%0d_wr_data", i), 32'(bus.wr_data), 32'(tbl[i].wdata));
         end
         chk($sformatf("vec%0d_cpu_ack", i), 32'(bus.cpu_ack), 32'(tbl[i].cpu));
         chk_cur($sformatf("vec%0d", i), int'(tbl[i].cx), int'(tbl[i].cy));
         tick();
      end

      // Simultaneous CPU and keyboard after reset: CPU first, single ack
      do_reset();
      bus.cpu_req = 1'b1; bus.cpu_addr = 12'd75; bus.cpu_data = 8'h5A;
      bus.kbd_valid = 1'b1; bus.kbd_char = 8'h78;
      #1;
      chk("arb_kbd_ready_lost", 32'(bus.kbd_ready), 0);
      tick();
      chk("arb_cpu_ack", 32'(bus.cpu_ack), 1);
      chk("arb_cpu_wr_en", 32'(bus.wr_en), 1);
      chk("arb_cpu_wr_addr", 32'(bus.wr_addr), 75);
      chk("arb_cpu_wr_data", 32'(bus.wr_data), 32'h5A);
      chk("arb_kbd_ready_won", 32'(bus.kbd_ready), 1);
      tick();
      bus.cpu_req = 1'b0; bus.kbd_valid = 1'b0;
      chk("arb_no_second_ack", 32'(bus.cpu_ack), 0);
      chk("arb_kbd_wr_en", 32'(bus.wr_en), 1);
      chk("arb_kbd_wr_addr", 32'(bus.wr_addr), 0);
      chk("arb_kbd_wr_data", 32'(bus.wr_data), 32'h78);
      chk_cur("arb", 1, 0);
      tick();
      chk("arb_idle_wr_en", 32'(bus.wr_en), 0);
      chk("arb_idle_ack", 32'(bus.cpu_ack), 0);

      // Column wrap mid-screen, then last-row wrap into line clear
      send_n(8'h61, 68);
      chk_cur("col68", 69, 0);
      send_kbd(8'h5A);
      chk("colwrap_wr_addr", 32'(bus.wr_addr), 69);
      chk_cur("colwrap", 0, 1);
      send_n(8'h0A, 28);
      send_n(8'h61, 69);
      chk_cur("last_cell", 69, 29);
      send_kbd(8'h51);
      chk("q_wr_en", 32'(bus.wr_en), 1);
      chk("q_wr_addr", 32'(bus.wr_addr), 2099);
      chk("q_wr_data", 32'(bus.wr_data), 32'h51);
      chk("q_busy", 32'(bus.busy), 1);
      chk_cur("q", 0, 0);
      bus.cpu_req = 1'b1; bus.cpu_addr = 12'd5; bus.cpu_data = 8'h55;
      #1;
      chk("lineclr_kbd_ready", 32'(bus.kbd_ready), 0);
      for (int i = 0; i < 70; i++) begin
         tick();
         chk($sformatf("lineclr%0d_wr_en", i), 32'(bus.wr_en), 1);
         chk($sformatf("lineclr%0d_wr_addr", i), 32'(bus.wr_addr), 32'(i));
         chk($sformatf("lineclr%0d_wr_data", i), 32'(bus.wr_data), 32'h20);
         chk($sformatf("lineclr%0d_cpu_ack", i), 32'(bus.cpu_ack), 0);
         if (i < 69) begin
            chk($sformatf("lineclr%0d_busy", i), 32'(bus.busy), 1);
            chk($sformatf("lineclr%0d_kbd_ready", i), 32'(bus.kbd_ready), 0);
         end else begin
            chk("lineclr_end_busy", 32'(bus.busy), 0);
         end
      end
      tick();
      chk("held_cpu_ack", 32'(bus.cpu_ack), 1);
      chk("held_cpu_wr_addr", 32'(bus.wr_addr), 5);
      chk("held_cpu_wr_data", 32'(bus.wr_data), 32'h55);
      chk_cur("held_cpu", 0, 0);
      bus.cpu_req = 1'b0;
      tick();

      // Newline on last row starts a line clear; reset aborts it
      send_n(8'h0A, 29);
      chk_cur("lf29", 0, 29);
      send_kbd(8'h0A);
      chk("lfwrap_wr_en", 32'(bus.wr_en), 0);
      chk("lfwrap_busy", 32'(bus.busy), 1);
      chk_cur("lfwrap", 0, 0);
      tick();
      chk("lfwrap_first_wr_en", 32'(bus.wr_en), 1);
      chk("lfwrap_first_wr_addr", 32'(bus.wr_addr), 0);
      tick();
      tick();
      chk("lfwrap_third_wr_addr", 32'(bus.wr_addr), 2);
      do_reset();
`ifndef VGA_CON_CLEAR_EN
      tick();
      chk("post_rst_wr_en", 32'(bus.wr_en), 0);
      chk("post_rst_kbd_ready", 32'(bus.kbd_ready), 1);
`else
      send_n(8'h0A, 4);
      send_n(8'h63, 10);
      chk_cur("pre_ff", 10, 4);
      send_kbd(8'h0C);
      chk("ff_wr_en", 32'(bus.wr_en), 0);
      chk("ff_busy", 32'(bus.busy), 1);
      chk_clear();
      send_kbd(8'h0C);
      repeat (100) tick();
      do_reset();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
